// File: rtl/pipelined_write_decoder_if.sv
// pipelined_write_decoder_if: request/stall/flush inputs and one-hot write-enable outputs of the decoder.
interface pipelined_write_decoder_if #(parameter int IN_WIDTH = 5);
  logic                     in_valid;
  logic                     enable;
  logic [IN_WIDTH-1:0]      in_addr;
  logic                     stall;
  logic                     flush;
  logic [2**IN_WIDTH-1:0]   out;
  logic                     out_valid;
  logic [IN_WIDTH-1:0]      out_addr;
  modport master (output in_valid, enable, in_addr, stall, flush, input out, out_valid, out_addr);
  modport slave  (input in_valid, enable, in_addr, stall, flush, output out, out_valid, out_addr);
endinterface

// File: rtl/pipelined_write_decoder.sv
// pipelined_write_decoder: STAGES-deep valid/address pipeline feeding a one-hot register write-enable decoder.
// Optional macro DEC_ZERO_REG_MASK_EN suppresses the write-enable for the all-ones address.
module pipelined_write_decoder #(
  parameter int IN_WIDTH = 5,
  parameter int STAGES   = 2
) (
  input logic clk,
  input logic reset,
  pipelined_write_decoder_if.slave bus
);
  localparam int OUT_W = 2**IN_WIDTH;
  logic [STAGES-1:0]   v_q, v_d;
  logic [IN_WIDTH-1:0] a_q [STAGES];
  logic [IN_WIDTH-1:0] a_d [STAGES];
  logic [IN_WIDTH-1:0] fin_addr;
  logic                fin_valid;
  logic                wr_en;
  // Flush clears only valids; addresses hold since they are don't-care once invalid.
  always_comb begin
    v_d = v_q;
    a_d = a_q;
    if (bus.flush) begin
      v_d = '0;
    end else if (!bus.stall) begin
      v_d[0] = bus.in_valid & bus.enable;
      a_d[0] = bus.in_addr;
      for (int k = 1; k < STAGES; k++) begin
        v_d[k] = v_q[k-1];
        a_d[k] = a_q[k-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) a_q[k] <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
    end
  end
  assign fin_addr  = a_q[STAGES-1];
  assign fin_valid = v_q[STAGES-1];
`ifdef DEC_ZERO_REG_MASK_EN
  assign wr_en = fin_valid & ~(&fin_addr);
`else
  assign wr_en = fin_valid;
`endif
  assign bus.out       = wr_en ? ({{(OUT_W-1){1'b0}}, 1'b1} << fin_addr) : '0;
  assign bus.out_valid = fin_valid;
  assign bus.out_addr  = fin_addr;
endmodule

// File: tb/tb_pipelined_write_decoder.sv
// tb_pipelined_write_decoder: directed checks of the 5-bit, 2-stage write decoder.
module tb_pipelined_write_decoder;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int errors = 0;
  pipelined_write_decoder_if #(.IN_WIDTH(5)) bus();
  pipelined_write_decoder #(.IN_WIDTH(5), .STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid = 0; bus.enable = 1; bus.in_addr = 0; bus.stall = 0; bus.flush = 0;
  endtask
  task automatic test_reset();
    idle();
    bus.in_valid = 1; bus.in_addr = 7; reset = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.out !== 32'h0 || bus.out_valid !== 1'b0 || bus.out_addr !== 5'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d out=%h valid=%b addr=%0d want 0/0/0", i, bus.out, bus.out_valid, bus.out_addr);
      end
    end
    reset = 1;
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_edge1 out=%h valid=%b want 0/0", bus.out, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out !== 32'h80 || bus.out_valid !== 1'b1 || bus.out_addr !== 5'd7) begin
      errors++;
      $display("FAIL reset_first_input out=%h valid=%b addr=%0d want 00000080/1/7", bus.out, bus.out_valid, bus.out_addr);
    end
    step();
    checks++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain out=%h valid=%b want 0/0", bus.out, bus.out_valid);
    end
  endtask
  task automatic test_stream();
    logic [4:0]  addrs [4] = '{5'd0, 5'd1, 5'd30, 5'd31};
    logic [31:0] exp   [4] = '{32'h1, 32'h2, 32'h4000_0000, 32'h8000_0000};
`ifdef DEC_ZERO_REG_MASK_EN
    exp[3] = 32'h0;
`endif
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i < 4);
      bus.in_addr  = (i < 4) ? addrs[i] : 5'd0;
      step();
      if (i > 0) begin
        checks++;
        if (bus.out !== exp[i-1] || bus.out_valid !== 1'b1 || bus.out_addr !== addrs[i-1]) begin
          errors++;
          $display("FAIL stream[%0d] out=%h valid=%b addr=%0d want %h/1/%0d", i-1, bus.out, bus.out_valid, bus.out_addr, exp[i-1], addrs[i-1]);
        end
      end
    end
    bus.in_valid = 0;
    step();
    checks++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end out=%h valid=%b want 0/0", bus.out, bus.out_valid);
    end
  endtask
  task automatic test_enable_gating();
    idle();
    bus.in_valid = 1; bus.enable = 0; bus.in_addr = 5;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL enable_gating cyc%0d out=%h valid=%b want 0/0", i, bus.out, bus.out_valid);
      end
    end
    idle();
    step();
    step();
  endtask
  task automatic test_stall();
    idle();
    bus.in_valid = 1; bus.in_addr = 3;
    step();
    bus.in_addr = 4; bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d out=%h valid=%b want 0/0", i, bus.out, bus.out_valid);
      end
    end
    idle();
    step();
    checks++;
    if (bus.out !== 32'h8 || bus.out_addr !== 5'd3) begin
      errors++;
      $display("FAIL stall_release out=%h addr=%0d want 00000008/3", bus.out, bus.out_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.out !== 32'h0) begin
        errors++;
        $display("FAIL stall_no_addr4 cyc%0d out=%h want 0", i, bus.out);
      end
    end
  endtask
  task automatic test_flush();
    idle();
    bus.in_valid = 1; bus.in_addr = 9;
    step();
    bus.in_addr = 10; bus.flush = 1; bus.stall = 1;
    step();
    idle();
    checks++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_edge out=%h valid=%b want 0/0", bus.out, bus.out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_after cyc%0d out=%h valid=%b want 0/0", i, bus.out, bus.out_valid);
      end
    end
  endtask
  task automatic test_reset_mid();
    idle();
    bus.in_valid = 1; bus.in_addr = 12;
    step();
    bus.in_valid = 0; reset = 0;
    step();
    reset = 1;
    checks++;
    if (bus.out !== 32'h0 || bus.out_valid !== 1'b0 || bus.out_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_edge out=%h valid=%b addr=%0d want 0/0/0", bus.out, bus.out_valid, bus.out_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after cyc%0d out=%h valid=%b want 0/0", i, bus.out, bus.out_valid);
      end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_stream();
    test_enable_gating();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
